// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D cache line-port arbiter.
package cache_arbiter_pkg;

    localparam int DEF_LINE_W = 256;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache, memory-adaptor and statistics signals.
// slave is the arbiter's view, master is the view of everything around it.
interface cache_arbiter_if
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    logic [31:0]       num_conflict;
    logic [31:0]       num_i_grant;
    logic [31:0]       num_d_grant;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output mem_read, mem_write, mem_addr, mem_wdata,
        output num_conflict, num_i_grant, num_d_grant
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        input  num_conflict, num_i_grant, num_d_grant
    );

endinterface

// File: rtl/cache_arbiter_perf.sv
// Free-running 32-bit wrapping statistics counters for the arbiter.
module arb_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        conflict_i,
    input  logic        i_grant_i,
    input  logic        d_grant_i,
    output logic [31:0] num_conflict_o,
    output logic [31:0] num_i_grant_o,
    output logic [31:0] num_d_grant_o
);

    // Count each strobe; natural 32-bit wrap is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_conflict_o <= '0;
            num_i_grant_o  <= '0;
            num_d_grant_o  <= '0;
        end else begin
            if (conflict_i) num_conflict_o <= num_conflict_o + 32'd1;
            if (i_grant_i)  num_i_grant_o  <= num_i_grant_o + 32'd1;
            if (d_grant_i)  num_d_grant_o  <= num_d_grant_o + 32'd1;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates the single memory line port between I-cache and D-cache.
// D wins by default; I is forced after STARVE_MAX D grants made while I waited.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int LINE_W     = DEF_LINE_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    arb_op_t           op_q, op_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;

    logic i_req, d_req, starve_hit;
    logic i_grant, d_grant, conflict;
    logic i_resp, d_resp;

    assign i_req      = bus.i_read;
    assign d_req      = bus.d_read | bus.d_write;
    assign starve_hit = (starve_cnt_q == SW'(STARVE_MAX));

    // State, hold registers and starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            op_q         <= OP_READ;
            wdata_q      <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next-state, grant bookkeeping and completion pulses.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        starve_cnt_d = starve_cnt_q;
        i_grant      = 1'b0;
        d_grant      = 1'b0;
        conflict     = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (state_q)
            IDLE: begin
                conflict = i_req & d_req;
                if (i_req && (!d_req || starve_hit)) begin
                    i_grant      = 1'b1;
                    state_d      = SERVE_I;
                    addr_d       = bus.i_addr;
                    op_d         = OP_READ;
                    wdata_d      = bus.d_wdata;
                    starve_cnt_d = '0;
                end else if (d_req) begin
                    d_grant = 1'b1;
                    state_d = SERVE_D;
                    addr_d  = bus.d_addr;
                    // A simultaneous read+write is a writeback.
                    op_d    = bus.d_write ? OP_WRITE : OP_READ;
                    wdata_d = bus.d_wdata;
                    if (i_req && !starve_hit)
                        starve_cnt_d = starve_cnt_q + SW'(1);
                end
            end
            SERVE_I: begin
                if (bus.mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = RECOVER;
                end
            end
            SERVE_D: begin
                if (bus.mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = RECOVER;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes decode only from state and latched op, never from requesters.
    assign bus.mem_read  = (state_q == SERVE_I) || (state_q == SERVE_D && op_q == OP_READ);
    assign bus.mem_write = (state_q == SERVE_D) && (op_q == OP_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.i_resp    = i_resp;
    assign bus.d_resp    = d_resp;

    arb_perf_counters u_perf (
        .clk            (clk),
        .rst            (rst),
        .conflict_i     (conflict),
        .i_grant_i      (i_grant),
        .d_grant_i      (d_grant),
        .num_conflict_o (bus.num_conflict),
        .num_i_grant_o  (bus.num_i_grant),
        .num_d_grant_o  (bus.num_d_grant)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: memory model with programmable latency,
// response monitor recording the grant order, one task per scenario.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int          mem_lat = 4;
    int          mem_cnt = 0;
    logic [LW-1:0] rline = '0;
    byte         order[$];
    int          i_pulses = 0;
    int          d_pulses = 0;

    assign bus.mem_rdata = rline;

    // Memory model: pulse mem_resp in the mem_lat-th cycle of a strobe.
    initial begin
        bus.mem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_resp = 1'b0;
            if (rst || !(bus.mem_read || bus.mem_write)) begin
                mem_cnt = 0;
            end else begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    bus.mem_resp = 1'b1;
                    mem_cnt = 0;
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (bus.i_resp) begin
            order.push_back("I");
            i_pulses++;
        end
        if (bus.d_resp) begin
            order.push_back("D");
            d_pulses++;
        end
    end

    task automatic clear_inputs();
        bus.i_read  = 1'b0;
        bus.i_addr  = '0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        order.delete();
        i_pulses = 0;
        d_pulses = 0;
    endtask

    // Bounded wait for a completion pulse; cyc counts negedges waited.
    task automatic wait_resp(input bit is_i, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            cyc++;
            if (is_i ? bus.i_resp : bus.d_resp) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        rline = '0;
        #12;
        total++;
        if ({bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp});
        end
        total++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_hold got addr=%0h wdata=%0h exp=0", bus.mem_addr, bus.mem_wdata);
        end
        total++;
        if ({bus.num_conflict, bus.num_i_grant, bus.num_d_grant} !== '0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                     bus.num_conflict, bus.num_i_grant, bus.num_d_grant);
        end
        total++;
        if (dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE);
        end
        do_reset();
    endtask

    task automatic test_i_only();
        bit ok;
        int cyc;
        do_reset();
        mem_lat = 10;
        rline = {32{8'hA5}};
        bus.i_addr = 32'h0000_0060;
        bus.i_read = 1'b1;
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL ionly_cycle0 got mem_read=%b exp=0", bus.mem_read);
        end
        @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h60) begin
            bad++;
            $display("FAIL ionly_strobe got rd=%b wr=%b addr=%0h exp rd=1 wr=0 addr=60",
                     bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        wait_resp(1'b1, ok, cyc);
        total++;
        if (!ok || cyc != 9) begin
            bad++;
            $display("FAIL ionly_latency got ok=%0d cyc=%0d exp ok=1 cyc=9", ok, cyc);
        end
        total++;
        if (bus.i_rdata !== {32{8'hA5}}) begin
            bad++;
            $display("FAIL ionly_rdata got=%0h exp=%0h", bus.i_rdata, {32{8'hA5}});
        end
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (i_pulses != 1 || d_pulses != 0) begin
            bad++;
            $display("FAIL ionly_pulses got i=%0d d=%0d exp i=1 d=0", i_pulses, d_pulses);
        end
        total++;
        if (bus.num_i_grant !== 32'd1 || bus.num_d_grant !== 32'd0) begin
            bad++;
            $display("FAIL ionly_grants got i=%0d d=%0d exp i=1 d=0", bus.num_i_grant, bus.num_d_grant);
        end
    endtask

    task automatic test_d_write();
        bit ok;
        int cyc;
        do_reset();
        mem_lat = 8;
        bus.d_addr  = 32'h0000_1000;
        bus.d_wdata = {8{32'h1234_5678}};
        bus.d_write = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h1000) begin
            bad++;
            $display("FAIL dwr_strobe got wr=%b rd=%b addr=%0h exp wr=1 rd=0 addr=1000",
                     bus.mem_write, bus.mem_read, bus.mem_addr);
        end
        total++;
        if (bus.mem_wdata !== {8{32'h1234_5678}}) begin
            bad++;
            $display("FAIL dwr_wdata got=%0h exp=%0h", bus.mem_wdata, {8{32'h1234_5678}});
        end
        wait_resp(1'b0, ok, cyc);
        total++;
        if (!ok || cyc != 7) begin
            bad++;
            $display("FAIL dwr_latency got ok=%0d cyc=%0d exp ok=1 cyc=7", ok, cyc);
        end
        @(posedge clk);
        #1;
        bus.d_write = 1'b0;
        @(negedge clk);
        total++;
        if (dut.state_q !== RECOVER || bus.mem_write !== 1'b0 || bus.d_resp !== 1'b0) begin
            bad++;
            $display("FAIL dwr_recover got state=%0d wr=%b resp=%b exp state=3 wr=0 resp=0",
                     dut.state_q, bus.mem_write, bus.d_resp);
        end
        @(negedge clk);
        total++;
        if (dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL dwr_idle got state=%0d exp=%0d", dut.state_q, IDLE);
        end
        repeat (2) @(negedge clk);
        total++;
        if (d_pulses != 1 || i_pulses != 0 || bus.num_d_grant !== 32'd1) begin
            bad++;
            $display("FAIL dwr_pulses got d=%0d i=%0d dgrant=%0d exp d=1 i=0 dgrant=1",
                     d_pulses, i_pulses, bus.num_d_grant);
        end
    endtask

    task automatic test_conflict();
        bit ok;
        int cyc;
        do_reset();
        mem_lat = 3;
        bus.i_addr = 32'h200;
        bus.d_addr = 32'h300;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_addr !== 32'h300 || bus.mem_read !== 1'b1) begin
            bad++;
            $display("FAIL conf_first got addr=%0h rd=%b exp addr=300 rd=1", bus.mem_addr, bus.mem_read);
        end
        wait_resp(1'b0, ok, cyc);
        @(posedge clk);
        #1;
        bus.d_read = 1'b0;
        wait_resp(1'b1, ok, cyc);
        total++;
        if (!ok || bus.i_rdata !== rline) begin
            bad++;
            $display("FAIL conf_second got ok=%0d exp ok=1", ok);
        end
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (order.size() != 2 || order[0] != "D" || order[1] != "I") begin
            bad++;
            $display("FAIL conf_order got n=%0d exp DI", order.size());
        end
        total++;
        if (bus.num_conflict < 32'd1 || bus.num_d_grant !== 32'd1 || bus.num_i_grant !== 32'd1) begin
            bad++;
            $display("FAIL conf_counters got c=%0d d=%0d i=%0d exp c>=1 d=1 i=1",
                     bus.num_conflict, bus.num_d_grant, bus.num_i_grant);
        end
    endtask

    task automatic test_starvation();
        bit    seen_i = 1'b0;
        string got = "";
        do_reset();
        mem_lat = 2;
        bus.i_addr = 32'h400;
        bus.d_addr = 32'h500;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        for (int n = 0; n < 300 && order.size() < 10; n++) begin
            @(negedge clk);
            if (bus.i_resp && !seen_i) begin
                seen_i = 1'b1;
                total++;
                if (dut.starve_cnt_q !== 3'd0) begin
                    bad++;
                    $display("FAIL starve_clear got=%0d exp=0", dut.starve_cnt_q);
                end
            end
            #1;
        end
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        repeat (3) @(negedge clk);
        foreach (order[k]) got = $sformatf("%s%c", got, order[k]);
        total++;
        if (got != "DDDDIDDDDI") begin
            bad++;
            $display("FAIL starve_order got=%s exp=DDDDIDDDDI", got);
        end
        total++;
        if (bus.num_d_grant !== 32'd8 || bus.num_i_grant !== 32'd2 || bus.num_conflict !== 32'd10) begin
            bad++;
            $display("FAIL starve_counters got d=%0d i=%0d c=%0d exp d=8 i=2 c=10",
                     bus.num_d_grant, bus.num_i_grant, bus.num_conflict);
        end
    endtask

    task automatic test_rw_collision();
        bit ok;
        int cyc;
        do_reset();
        mem_lat = 2;
        bus.d_addr  = 32'h40;
        bus.d_wdata = {4{64'hDEAD_BEEF_0BAD_F00D}};
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL rw_collision got wr=%b rd=%b exp wr=1 rd=0", bus.mem_write, bus.mem_read);
        end
        wait_resp(1'b0, ok, cyc);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rw_complete got ok=0 exp ok=1");
        end
        @(posedge clk);
        #1;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int cyc;
        do_reset();
        mem_lat = 1000;
        bus.d_addr  = 32'h2000;
        bus.d_wdata = {8{32'hCAFE_F00D}};
        bus.d_write = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_write !== 1'b1) begin
            bad++;
            $display("FAIL midrst_pre got wr=%b exp=1", bus.mem_write);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL midrst_drop got wr=%b rd=%b exp wr=0 rd=0", bus.mem_write, bus.mem_read);
        end
        total++;
        if ({bus.num_conflict, bus.num_i_grant, bus.num_d_grant} !== '0) begin
            bad++;
            $display("FAIL midrst_counters got=%0d/%0d/%0d exp=0/0/0",
                     bus.num_conflict, bus.num_i_grant, bus.num_d_grant);
        end
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_lat = 4;
        rline = {16{16'h5A3C}};
        bus.i_addr = 32'h80;
        bus.i_read = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h80) begin
            bad++;
            $display("FAIL midrst_after got rd=%b addr=%0h exp rd=1 addr=80", bus.mem_read, bus.mem_addr);
        end
        wait_resp(1'b1, ok, cyc);
        total++;
        if (!ok || cyc != 3 || bus.i_rdata !== {16{16'h5A3C}}) begin
            bad++;
            $display("FAIL midrst_resp got ok=%0d cyc=%0d rdata=%0h exp ok=1 cyc=3 rdata=%0h",
                     ok, cyc, bus.i_rdata, {16{16'h5A3C}});
        end
        @(posedge clk);
        #1;
        bus.i_read = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.num_i_grant !== 32'd1 || bus.num_d_grant !== 32'd0) begin
            bad++;
            $display("FAIL midrst_grants got i=%0d d=%0d exp i=1 d=0", bus.num_i_grant, bus.num_d_grant);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_i_only();
        test_d_write();
        test_conflict();
        test_starvation();
        test_rw_collision();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
